// File: rtl/rib_wait_slave.sv
// Word-organised slow memory responder for the core's data-side bus.
// Each access stalls the core via hold_o for a fixed number of wait states.
module rib_wait_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hold_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_hit;
  logic [31:0]     r_wdata;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_mem [DEPTH];

  logic [31:0]     w_off;
  logic            w_hit;
  logic            w_last;

  // Unsigned wrap makes addresses below the base land far above SPAN.
  assign w_off  = addr_i - BASE_ADDR;
  assign w_hit  = (w_off < SPAN) && (addr_i[1:0] == 2'b00);
  assign w_last = (r_state == StWait) && (r_cnt == 4'd0);

  always_comb begin
    w_state_d = r_state;
    hold_o    = 1'b0;
    unique case (r_state)
      StIdle: begin
        hold_o = req_i;
        if (req_i) w_state_d = StWait;
      end
      StWait: begin
        hold_o = 1'b1;
        if (r_cnt == 4'd0) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (rst) hold_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && req_i) begin
        r_we    <= we_i;
        r_wdata <= wdata_i;
        r_idx   <= w_off[AW+1:2];
        r_hit   <= w_hit;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == StWait && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last && !r_we) rdata_o <= r_hit ? r_mem[r_idx] : 32'd0;
      // A completing miss beats a simultaneous clear.
      if (w_last && !r_hit)  err_o <= 1'b1;
      else if (err_clr_i)    err_o <= 1'b0;
    end
  end

  // Reset forces StIdle asynchronously, so an abandoned write never commits.
  always_ff @(posedge clk) begin
    if (w_last && r_hit && r_we) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_rib_wait_slave.sv
// Scoreboard bench for rib_wait_slave: expected results are queued at request time
// and compared when the DUT reaches its completion cycle.
module tb_rib_wait_slave;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          W    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        hold;
  logic        err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  int          checks = 0;
  int          errors = 0;

  rib_wait_slave #(
    .BASE_ADDR  (BASE),
    .DEPTH      (1024),
    .WAIT_CYCLES(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .hold_o   (hold),
    .err_o    (err),
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h0000_1000) && (a[1:0] == 2'b00);
  endfunction

  // One complete access starting in an IDLE cycle; returns at the end of DONE.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit drop, input bit clr, input bit keep, input string name);
    exp_t e;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; err_clr = clr;
    if (m_hit(a)) begin
      if (w) m_mem[a] = d;
      else   m_rdata = m_mem[a];
    end else if (!w) begin
      m_rdata = 32'd0;
    end
    if (!m_hit(a)) m_err = 1'b1;
    else if (clr)  m_err = 1'b0;
    e.rdata = m_rdata;
    e.err   = m_err;
    sb_q.push_back(e);
    #1;
    checks++;
    if (hold !== 1'b1) begin
      errors++; $display("FAIL %s hold_req_cycle: got %b want 1", name, hold);
    end
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (drop) begin
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFF0; wdata = ~d;
      end
      #1;
      checks++;
      if (hold !== 1'b1) begin
        errors++; $display("FAIL %s hold_wait%0d: got %b want 1", name, i, hold);
      end
    end
    @(posedge clk); #1;
    if (!keep) req = 1'b0;
    err_clr = 1'b0;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (hold !== 1'b0) begin
      errors++; $display("FAIL %s hold_done: got %b want 0", name, hold);
    end
    checks++;
    if (rdata !== e.rdata) begin
      errors++; $display("FAIL %s rdata: got %h want %h", name, rdata, e.rdata);
    end
    checks++;
    if (err !== e.err) begin
      errors++; $display("FAIL %s err: got %b want %b", name, err, e.err);
    end
    if (keep) begin
      @(posedge clk); #1;
      req = 1'b0;
      #1;
      checks++;
      if (hold !== 1'b0) begin
        errors++; $display("FAIL %s idle_after_done: got %b want 0", name, hold);
      end
    end
  endtask

  task automatic clear_err(input string name);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL %s err_clr: got %b want 0", name, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = BASE;
    #1;
    checks++;
    if (hold !== 1'b0) begin
      errors++; $display("FAIL reset hold: got %b want 0", hold);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++; $display("FAIL reset rdata: got %h want 0", rdata);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset err: got %b want 0", err);
    end
    @(posedge clk); @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_write_read();
    do_access(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 0, 0, 0, "wr_10");
    do_access(1'b0, BASE + 32'h10, 32'h0, 0, 0, 0, "rd_10");
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, BASE + 32'h40, 32'h0101_0101, 0, 0, 0, "b2b_wr40");
    do_access(1'b1, BASE + 32'h44, 32'h0202_0202, 0, 0, 0, "b2b_wr44");
    do_access(1'b0, BASE + 32'h40, 32'h0, 0, 0, 0, "b2b_rd40");
    do_access(1'b0, BASE + 32'h44, 32'h0, 0, 0, 0, "b2b_rd44");
  endtask

  task automatic test_errors();
    do_access(1'b0, 32'h0000_0004, 32'h0, 0, 0, 0, "rd_below_base");
    clear_err("clr1");
    do_access(1'b1, BASE, 32'h1111_2222, 0, 0, 0, "wr_word0");
    do_access(1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 0, 0, 0, "wr_misaligned");
    do_access(1'b0, BASE, 32'h0, 0, 0, 0, "rd_word0_after_mis");
    clear_err("clr2");
  endtask

  task automatic test_set_wins();
    do_access(1'b0, 32'h2000_0000, 32'h0, 0, 1, 0, "set_vs_clr_miss");
    clear_err("clr3");
    do_access(1'b0, BASE + 32'h10, 32'h0, 0, 1, 0, "clr_during_hit");
  endtask

  task automatic test_req_drop();
    do_access(1'b1, BASE + 32'h20, 32'h1234_5678, 1, 0, 0, "wr_drop");
    do_access(1'b0, BASE + 32'h20, 32'h0, 0, 0, 0, "rd_after_drop");
  endtask

  task automatic test_reset_mid_write();
    do_access(1'b1, BASE + 32'h30, 32'h0, 0, 0, 0, "wr30_zero");
    do_access(1'b1, 32'h0000_0100, 32'h5, 0, 0, 0, "wr_miss_pre");
    do_access(1'b0, BASE + 32'h10, 32'h0, 0, 0, 0, "rd10_pre");
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = BASE + 32'h30; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (hold !== 1'b0) begin
      errors++; $display("FAIL rst_mid hold: got %b want 0", hold);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++; $display("FAIL rst_mid rdata: got %h want 0", rdata);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rst_mid err: got %b want 0", err);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    m_rdata = 32'd0; m_err = 1'b0;
    do_access(1'b0, BASE + 32'h30, 32'h0, 0, 0, 0, "rd30_after_rst");
  endtask

  task automatic test_top_boundary();
    do_access(1'b1, BASE + 32'hFFC, 32'h5A5A_5A5A, 0, 0, 0, "wr_last");
    do_access(1'b0, BASE + 32'hFFC, 32'h0, 0, 0, 1, "rd_last_keep_req");
    do_access(1'b1, BASE + 32'h1000, 32'hCAFE_F00D, 0, 0, 0, "wr_past_top");
    do_access(1'b0, BASE, 32'h0, 0, 0, 0, "rd_word0_no_wrap");
    do_access(1'b0, BASE + 32'h1000, 32'h0, 0, 0, 0, "rd_past_top");
    clear_err("clr4");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_set_wins();
    test_req_drop();
    test_reset_mid_write();
    test_top_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rib_wait_slave.md
Name: rib_wait_slave

Overview:
- Bus responder for the core's data-side peripheral port: it accepts the request the core drives out (address, write data, request, write enable) and returns read data and a bus-hold flag.
- Models a slow, word-organised on-chip memory with a programmable number of wait states.
- Holds the pipeline through the core's bus-hold input until each access completes.
- Sits between the core's data port and the bus-hold/read-data inputs of the core top, in place of a zero-latency RAM.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of word 0; must be aligned to DEPTH*4.
- DEPTH, 1024, number of 32-bit words (power of two, 16..65536).
- WAIT_CYCLES, 2, wait states per access (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  access request from the core.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data.
- hold_o  out  1  bus hold to the core; stalls the pipeline while high.
- err_o  out  1  sticky access-error flag.
- err_clr_i  in  1  synchronous clear of err_o.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, rdata_o=0, err_o=0, counter=0, latched request=0. hold_o=0 while rst is high. Memory contents are not reset.
- Address decode:
  - off = addr_i - BASE_ADDR (32-bit unsigned).
  - hit = (off < DEPTH*4) && (addr_i[1:0]==0).
  - Word index = off[log2(DEPTH)+1:2].
- States: IDLE, WAIT, DONE.
- IDLE:
  - hold_o = req_i (combinational), so the core stalls in the same cycle it raises the request.
  - On req_i=1: latch we_i, wdata_i, word index and hit; load counter=WAIT_CYCLES-1; go to WAIT.
- WAIT:
  - hold_o=1.
  - Counter decrements each cycle. Input changes, including req_i dropping, are ignored; the latched access always completes.
  - When counter==0 with hit=1: a write updates mem[index]; a read loads rdata_o<=mem[index]. Then go to DONE.
  - When counter==0 with hit=0: no memory write; a read loads rdata_o<=0; err_o<=1. Then go to DONE.
- DONE:
  - hold_o=0; rdata_o valid. The core consumes the result and advances this cycle.
  - req_i is ignored in DONE (it still belongs to the finished access). Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle T → hold_o high for cycles T..T+WAIT_CYCLES (WAIT_CYCLES+1 cycles).
  - DONE at T+WAIT_CYCLES+1.
  - Back-to-back accesses: minimum period WAIT_CYCLES+2 cycles.
- rdata_o holds its last loaded value outside DONE; writes do not change it.
- err_o:
  - Set at completion of any miss or misaligned access.
  - Cleared by err_clr_i=1 on a clock edge.
  - If set and clear coincide in the same cycle, set wins.
- Reset asserted mid-access: access abandoned, no memory write, outputs return to reset values immediately.

Test Plan:
- Write then read, WAIT_CYCLES=2: write addr 0x1000_0010, data 0xDEADBEEF → hold_o high 3 cycles, then DONE. Read same address → after 3 hold cycles, rdata_o=0xDEADBEEF in DONE.
- Hold timing: req_i rises at cycle 5 → hold_o=1 at cycles 5,6,7; hold_o=0 at cycle 8 (DONE); state IDLE at cycle 9.
- Error handling:
  - Read 0x0000_0004 (below base) → rdata_o=0, err_o=1, memory unchanged.
  - Then err_clr_i pulse → err_o=0.
  - Misaligned write 0x1000_0002 → err_o=1, word 0 unchanged.
- Request drop mid-access: write 0x1000_0020 = 0x12345678 with req_i deasserted in cycle T+1 → write still commits; subsequent read returns 0x12345678.
- Reset mid-write: assert rst during WAIT of a write to 0x1000_0030 = 0xA5A5A5A5 (prior value 0x0) → hold_o=0, rdata_o=0 immediately; after release, a read returns 0x0.
- Top boundary: DEPTH=1024; write last word 0x1000_0FFC = 0x5A5A5A5A → readback correct. Address 0x1000_1000 → err_o=1, no wrap to word 0.
